rv32i_decode_stage: RTL and testbench
=====================================

// Module: rv32i_decode_stage
// PURPOSE
//  Pipelined RV32I decode stage: the producer of the 4-bit ALU op code that the ALU consumes.
//  Takes a fetched instruction and PC over valid/ready and registers decoded control,
//  register indices, immediate and operand selects in one output stage. Flags illegal encodings.
//  Sits between fetch and execute; execute applies back-pressure via out_ready.
// PARAMETERS
//  XLEN  32  data/PC width; only 32 supported
// PORTS
//  clk        in   1   clock; all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  flush      in   1   sync squash (branch redirect)
//  in_valid   in   1   instr/pc valid
//  in_ready   out  1   stage can accept this cycle
//  in_instr   in   32  instruction word
//  in_pc      in   32  instruction address
//  out_valid  out  1   decoded bundle valid
//  out_ready  in   1   execute accepts bundle
//  out_pc     out  32  registered in_pc
//  alu_ctrl   out  4   0000 ADD,1000 SUB,0001 SLL,0010 SLT,0011 SLTU,0100 XOR,0101 SRL,1101 SRA,0110 OR,0111 AND
//  rs1,rs2,rd out  5   register indices (instr[19:15],[24:20],[11:7])
//  imm        out  32  sign-extended immediate (I/S/B/U/J by opcode)
//  op1_sel    out  2   00 rs1, 01 pc, 10 zero
//  op2_sel    out  1   0 rs2, 1 imm
//  reg_we     out  1   writeback enable; forced 0 when rd==0
//  mem_rd, mem_wr out 1 load / store
//  funct3_o   out  3   instr[14:12] (load/store size, branch condition)
//  branch, jump out 1  conditional branch / JAL|JALR
//  illegal    out  1   unsupported encoding
// BEHAVIOUR
//  Reset: out_valid=0; every registered output 0. No side effects until first accept.
//  in_ready = !flush && (!out_valid || out_ready) (combinational). Accept = in_valid && in_ready.
//  Latency: 1 cycle; accepted beat appears next cycle with out_valid=1.
//  Hold: out_valid && !out_ready -> all outputs stable, in_ready=0.
//  Drain: out_valid && out_ready && !accept -> out_valid=0 next cycle.
//  Simultaneous drain + accept: new bundle loaded, out_valid stays 1 (full throughput).
//  flush=1: out_valid=0 next cycle; no accept that cycle; wins over all other events.
//  Reset mid-operation: immediate clear, bundle discarded.
//  Decode (illegal=1 also forces reg_we, mem_rd, mem_wr, branch, jump = 0):
//   instr[1:0]!=11 -> illegal.
//   OP 0110011: alu_ctrl={f7[5],f3}; legal iff f7==0, or f7==0100000 && f3 in {000,101}.
//   OP-IMM 0010011: f3=001 needs f7==0 -> 0001; f3=101 f7 0/0100000 -> 0101/1101,
//     imm={27'b0,shamt}; other f3 -> {0,f3}, I-imm; op2_sel=1.
//   LOAD 0000011: f3 in {000,001,010,100,101}, ADD, I-imm, mem_rd=1.
//   STORE 0100011: f3 in {000,001,010}, ADD, S-imm, reg_we=0, mem_wr=1.
//   BRANCH 1100011: f3 010/011 illegal; 000/001 SUB, 100/101 SLT, 110/111 SLTU;
//     op2_sel=0, B-imm, branch=1, reg_we=0.
//   JAL 1101111: ADD, op1=pc, J-imm, jump=1. JALR 1100111: f3==000, ADD, op1=rs1, I-imm, jump=1.
//   LUI 0110111: ADD, op1=zero, U-imm. AUIPC 0010111: ADD, op1=pc, U-imm.
//   FENCE 0001111: legal no-op, all enables 0. Any other opcode -> illegal.
// TESTING
//  0x40B50533 (sub x10,x10,x11) -> alu_ctrl=1000, rs1=10, rs2=11, rd=10, reg_we=1, op2_sel=0
//  0x40335293 (srai x5,x6,3) -> alu_ctrl=1101, imm=3, op2_sel=1; f7=0x21 variant -> illegal=1, reg_we=0
//  0x123450B7 (lui x1,0x12345) -> imm=0x12345000, op1_sel=10, alu_ctrl=0000; rd=0 variant -> reg_we=0
//  Branch f3=110 -> alu_ctrl=0011, branch=1, reg_we=0; f3=010 -> illegal=1
//  Back-to-back stream, out_ready low 3 cycles mid-stream -> outputs frozen, in_ready=0, no beat lost/duplicated
//  flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, beat not taken; rst_n low mid-stream -> immediate clear

Source files
------------

// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage
// Single-register-stage RV32I decoder between fetch and execute.
// The fetch side hands over an instruction and its PC with valid/ready.
// The stage registers the decoded bundle and offers it to execute with valid/ready.
// The decoded bundle holds the ALU op, register indices, immediate, operand selects,
// memory/branch/jump enables and an illegal-encoding flag.
// flush squashes the held bundle and blocks acceptance in the same cycle.
module rv32i_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      alu_ctrl,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output logic [1:0]      op1_sel,
  output logic            op2_sel,
  output logic            reg_we,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      funct3_o,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // ALU op encodings seen by execute
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Operand-1 selects
  localparam logic [1:0] OP1_RS1  = 2'b00;
  localparam logic [1:0] OP1_PC   = 2'b01;
  localparam logic [1:0] OP1_ZERO = 2'b10;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Immediate extraction helpers; each returns a sign-extended 32-bit value.
  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    imm_i = {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    imm_u = {ins[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // Instruction fields
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];
  assign w_rd  = in_instr[11:7];

  // Raw decode results (before illegal / rd==0 gating)
  logic [3:0]  w_alu;
  logic [1:0]  w_op1;
  logic        w_op2;
  logic [31:0] w_imm;
  logic        w_we_raw;
  logic        w_mrd_raw;
  logic        w_mwr_raw;
  logic        w_br_raw;
  logic        w_jmp_raw;
  logic        w_ill;

  // Gated decode results that get registered
  logic        w_we;
  logic        w_mrd;
  logic        w_mwr;
  logic        w_br;
  logic        w_jmp;
  logic        w_accept;

  // Output-stage registers
  logic            r_out_valid;
  logic [XLEN-1:0] r_pc;
  logic [3:0]      r_alu;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [31:0]     r_imm;
  logic [1:0]      r_op1;
  logic            r_op2;
  logic            r_we;
  logic            r_mrd;
  logic            r_mwr;
  logic [2:0]      r_f3;
  logic            r_br;
  logic            r_jmp;
  logic            r_ill;

  // Instruction decode: opcode/funct fields to control, immediate and legality.
  always_comb begin
    w_alu     = ALU_ADD;
    w_op1     = OP1_RS1;
    w_op2     = 1'b0;
    w_imm     = 32'h0000_0000;
    w_we_raw  = 1'b0;
    w_mrd_raw = 1'b0;
    w_mwr_raw = 1'b0;
    w_br_raw  = 1'b0;
    w_jmp_raw = 1'b0;
    w_ill     = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      w_ill = 1'b1;
    end else begin
      case (w_opc)
        OPC_OP: begin
          w_alu    = {w_f7[5], w_f3};
          w_we_raw = 1'b1;
          if ((w_f7 == F7_ZERO) ||
              ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))) begin
            w_ill = 1'b0;
          end else begin
            w_ill = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          w_op2    = 1'b1;
          w_we_raw = 1'b1;
          case (w_f3)
            3'b001: begin
              w_alu = ALU_SLL;
              w_imm = {27'h0000000, in_instr[24:20]};
              if (w_f7 == F7_ZERO) begin
                w_ill = 1'b0;
              end else begin
                w_ill = 1'b1;
              end
            end
            3'b101: begin
              w_imm = {27'h0000000, in_instr[24:20]};
              if (w_f7 == F7_ZERO) begin
                w_alu = ALU_SRL;
              end else if (w_f7 == F7_ALT) begin
                w_alu = ALU_SRA;
              end else begin
                w_ill = 1'b1;
              end
            end
            default: begin
              w_alu = {1'b0, w_f3};
              w_imm = imm_i(in_instr);
            end
          endcase
        end
        OPC_LOAD: begin
          w_op2     = 1'b1;
          w_imm     = imm_i(in_instr);
          w_we_raw  = 1'b1;
          w_mrd_raw = 1'b1;
          case (w_f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ill = 1'b0;
            default:                                w_ill = 1'b1;
          endcase
        end
        OPC_STORE: begin
          w_op2     = 1'b1;
          w_imm     = imm_s(in_instr);
          w_mwr_raw = 1'b1;
          case (w_f3)
            3'b000, 3'b001, 3'b010: w_ill = 1'b0;
            default:                w_ill = 1'b1;
          endcase
        end
        OPC_BRANCH: begin
          w_imm    = imm_b(in_instr);
          w_br_raw = 1'b1;
          case (w_f3)
            3'b000, 3'b001: w_alu = ALU_SUB;
            3'b100, 3'b101: w_alu = ALU_SLT;
            3'b110, 3'b111: w_alu = ALU_SLTU;
            default:        w_ill = 1'b1;
          endcase
        end
        OPC_JAL: begin
          w_op1     = OP1_PC;
          w_op2     = 1'b1;
          w_imm     = imm_j(in_instr);
          w_we_raw  = 1'b1;
          w_jmp_raw = 1'b1;
        end
        OPC_JALR: begin
          w_op2     = 1'b1;
          w_imm     = imm_i(in_instr);
          w_we_raw  = 1'b1;
          w_jmp_raw = 1'b1;
          if (w_f3 == 3'b000) begin
            w_ill = 1'b0;
          end else begin
            w_ill = 1'b1;
          end
        end
        OPC_LUI: begin
          w_op1    = OP1_ZERO;
          w_op2    = 1'b1;
          w_imm    = imm_u(in_instr);
          w_we_raw = 1'b1;
        end
        OPC_AUIPC: begin
          w_op1    = OP1_PC;
          w_op2    = 1'b1;
          w_imm    = imm_u(in_instr);
          w_we_raw = 1'b1;
        end
        OPC_FENCE: begin
          w_ill = 1'b0;
        end
        default: begin
          w_ill = 1'b1;
        end
      endcase
    end
  end

  // An illegal encoding must never cause architectural side effects; writes to x0 are dropped.
  assign w_we  = w_we_raw  && !w_ill && (w_rd != 5'd0);
  assign w_mrd = w_mrd_raw && !w_ill;
  assign w_mwr = w_mwr_raw && !w_ill;
  assign w_br  = w_br_raw  && !w_ill;
  assign w_jmp = w_jmp_raw && !w_ill;

  // Handshake: a squash or a stalled full stage refuses new input.
  assign in_ready = !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Output stage: flush squashes, accept loads, drain empties, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_alu       <= 4'b0000;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_imm       <= 32'h0000_0000;
      r_op1       <= 2'b00;
      r_op2       <= 1'b0;
      r_we        <= 1'b0;
      r_mrd       <= 1'b0;
      r_mwr       <= 1'b0;
      r_f3        <= 3'b000;
      r_br        <= 1'b0;
      r_jmp       <= 1'b0;
      r_ill       <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_pc        <= in_pc;
      r_alu       <= w_alu;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_rd        <= w_rd;
      r_imm       <= w_imm;
      r_op1       <= w_op1;
      r_op2       <= w_op2;
      r_we        <= w_we;
      r_mrd       <= w_mrd;
      r_mwr       <= w_mwr;
      r_f3        <= w_f3;
      r_br        <= w_br;
      r_jmp       <= w_jmp;
      r_ill       <= w_ill;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_pc;
  assign alu_ctrl  = r_alu;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd        = r_rd;
  assign imm       = r_imm;
  assign op1_sel   = r_op1;
  assign op2_sel   = r_op2;
  assign reg_we    = r_we;
  assign mem_rd    = r_mrd;
  assign mem_wr    = r_mwr;
  assign funct3_o  = r_f3;
  assign branch    = r_br;
  assign jump      = r_jmp;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb_rv32i_decode_stage
// Directed-vector bench for rv32i_decode_stage with hand-computed expectations.
// It covers decode of each instruction class, illegal encodings, stall/drain handshakes,
// flush and asynchronous reset.
module tb_rv32i_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [1:0]  op1_sel;
  logic        op2_sel;
  logic        reg_we;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3_o;
  logic        branch;
  logic        jump;
  logic        illegal;

  int errors = 0;
  int checks = 0;
  logic [31:0] seen_q[$];

  localparam logic [31:0] ADDI = 32'h0010_0093; // addi x1,x0,1

  rv32i_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_ctrl(alu_ctrl), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .reg_we(reg_we),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3_o(funct3_o),
    .branch(branch), .jump(jump), .illegal(illegal)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every bundle handed to execute.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) seen_q.push_back(out_pc);
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat with execute ready; returns #1 after the capturing edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_instr  = ins;
    in_pc     = pc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_dec(input string tag, input logic [31:0] pc, input logic [3:0] e_alu,
                            input logic [1:0] e_op1, input logic e_op2,
                            input logic [31:0] e_imm, input logic chk_imm,
                            input logic e_we, input logic e_mrd, input logic e_mwr,
                            input logic e_br, input logic e_jmp);
    check_eq({tag, ".valid"}, out_valid, 32'd1);
    check_eq({tag, ".pc"}, out_pc, pc);
    check_eq({tag, ".illegal"}, illegal, 32'd0);
    check_eq({tag, ".alu"}, alu_ctrl, e_alu);
    check_eq({tag, ".op1"}, op1_sel, e_op1);
    check_eq({tag, ".op2"}, op2_sel, e_op2);
    if (chk_imm) check_eq({tag, ".imm"}, imm, e_imm);
    check_eq({tag, ".reg_we"}, reg_we, e_we);
    check_eq({tag, ".mem_rd"}, mem_rd, e_mrd);
    check_eq({tag, ".mem_wr"}, mem_wr, e_mwr);
    check_eq({tag, ".branch"}, branch, e_br);
    check_eq({tag, ".jump"}, jump, e_jmp);
  endtask

  task automatic expect_illegal(input string tag);
    check_eq({tag, ".valid"}, out_valid, 32'd1);
    check_eq({tag, ".illegal"}, illegal, 32'd1);
    check_eq({tag, ".reg_we"}, reg_we, 32'd0);
    check_eq({tag, ".mem_rd"}, mem_rd, 32'd0);
    check_eq({tag, ".mem_wr"}, mem_wr, 32'd0);
    check_eq({tag, ".branch"}, branch, 32'd0);
    check_eq({tag, ".jump"}, jump, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0000_0000;
    in_pc     = 32'h0000_0000;
    out_ready = 1'b0;
    #12;
    check_eq("rst.valid", out_valid, 32'd0);
    check_eq("rst.pc", out_pc, 32'd0);
    check_eq("rst.alu", alu_ctrl, 32'd0);
    check_eq("rst.imm", imm, 32'd0);
    check_eq("rst.reg_we", reg_we, 32'd0);
    check_eq("rst.in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle.valid", out_valid, 32'd0);

    // ---- decode vectors ----
    send(32'h40B5_0533, 32'h0000_0010); // sub x10,x10,x11
    expect_dec("sub", 32'h10, 4'b1000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sub.rs1", rs1, 32'd10);
    check_eq("sub.rs2", rs2, 32'd11);
    check_eq("sub.rd", rd, 32'd10);
    check_eq("sub.f3", funct3_o, 32'd0);

    send(32'h4033_5293, 32'h0000_0014); // srai x5,x6,3
    expect_dec("srai", 32'h14, 4'b1101, 2'b00, 1'b1, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("srai.rs1", rs1, 32'd6);
    check_eq("srai.rd", rd, 32'd5);
    send(32'h4233_5293, 32'h0000_0018); // f7=0100001 shift
    expect_illegal("srai_f7");

    send(32'h1234_50B7, 32'h0000_001C); // lui x1,0x12345
    expect_dec("lui", 32'h1C, 4'b0000, 2'b10, 1'b1, 32'h1234_5000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h1234_5037, 32'h0000_0020); // lui x0,0x12345
    expect_dec("lui_x0", 32'h20, 4'b0000, 2'b10, 1'b1, 32'h1234_5000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    send(32'h0020_E463, 32'h0000_0024); // bltu x1,x2,+8
    expect_dec("bltu", 32'h24, 4'b0011, 2'b00, 1'b0, 32'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("bltu.f3", funct3_o, 32'd6);
    send(32'h0020_A463, 32'h0000_0028); // branch f3=010
    expect_illegal("br_f3_010");
    send(32'hFE00_0EE3, 32'h0000_002C); // beq x0,x0,-4
    expect_dec("beq_neg", 32'h2C, 4'b1000, 2'b00, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    send(32'h0010_00EF, 32'h0000_0030); // jal x1,+0x800
    expect_dec("jal", 32'h30, 4'b0000, 2'b01, 1'b1, 32'h0000_0800, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0001_00E7, 32'h0000_0034); // jalr x1,0(x2)
    expect_dec("jalr", 32'h34, 4'b0000, 2'b00, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h0001_10E7, 32'h0000_0038); // jalr f3=001
    expect_illegal("jalr_f3");

    send(32'hFE55_2E23, 32'h0000_003C); // sw x5,-4(x10)
    expect_dec("sw", 32'h3C, 4'b0000, 2'b00, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h0101_2183, 32'h0000_0040); // lw x3,16(x2)
    expect_dec("lw", 32'h40, 4'b0000, 2'b00, 1'b1, 32'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send(32'h0101_3183, 32'h0000_0044); // load f3=011
    expect_illegal("ld_f3");

    send(32'h0000_1517, 32'h0000_0048); // auipc x10,1
    expect_dec("auipc", 32'h48, 4'b0000, 2'b01, 1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0FF0_000F, 32'h0000_004C); // fence
    expect_dec("fence", 32'h4C, 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    send(32'h40B5_1533, 32'h0000_0050); // R-type f7=0100000 f3=001
    expect_illegal("r_bad_f7");
    send(32'h0000_0000, 32'h0000_0054); // low bits 00
    expect_illegal("low_bits");
    send(32'h0000_007F, 32'h0000_0058); // unknown opcode
    expect_illegal("bad_opc");

    // ---- back-to-back stream with a 3-cycle stall ----
    @(posedge clk);
    #1;
    seen_q.delete();
    send(ADDI, 32'h100);
    in_pc    = 32'h104;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("str.pc104", out_pc, 32'h104);
    in_pc     = 32'h108;
    out_ready = 1'b0;
    #1;
    check_eq("stall.in_ready0", in_ready, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("stall.valid", out_valid, 32'd1);
      check_eq("stall.pc", out_pc, 32'h104);
      check_eq("stall.rd", rd, 32'd1);
      check_eq("stall.in_ready", in_ready, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("str.pc108", out_pc, 32'h108);
    in_pc = 32'h10C;
    @(posedge clk);
    #1;
    check_eq("str.pc10C", out_pc, 32'h10C);
    check_eq("str.valid10C", out_valid, 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("drain.valid", out_valid, 32'd0);
    check_eq("str.count", seen_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < seen_q.size()) check_eq("str.order", seen_q[i], 32'h100 + 32'(4 * i));
    end

    // ---- flush while full with an incoming beat ----
    send(ADDI, 32'h200);
    in_pc    = 32'h204;
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    check_eq("flush.in_ready", in_ready, 32'd0);
    @(posedge clk);
    #1;
    check_eq("flush.valid", out_valid, 32'd0);
    check_eq("flush.pc_kept", out_pc, 32'h200);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("flush.not_taken", out_valid, 32'd0);

    // ---- asynchronous reset mid-stream ----
    send(32'h4033_5293, 32'h300);
    check_eq("pre_rst.valid", out_valid, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.valid", out_valid, 32'd0);
    check_eq("arst.pc", out_pc, 32'd0);
    check_eq("arst.alu", alu_ctrl, 32'd0);
    check_eq("arst.imm", imm, 32'd0);
    check_eq("arst.rd", rd, 32'd0);
    check_eq("arst.reg_we", reg_we, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(ADDI, 32'h400);
    check_eq("post_rst.pc", out_pc, 32'h400);
    check_eq("post_rst.valid", out_valid, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
